// File: rtl/route_pkg.sv
// Shared definitions for the load routing controller.
//   load_state_t : sequencer states (IDLE, three load phases, DONE)
//   SEL_*        : demux select codes; SEL_IDLE makes the demux drive zeros
package route_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD0 = 3'd1,
        LOAD1 = 3'd2,
        LOAD2 = 3'd3,
        DONE  = 3'd4
    } load_state_t;

    localparam logic [1:0] SEL_DEST0 = 2'd0;
    localparam logic [1:0] SEL_DEST1 = 2'd1;
    localparam logic [1:0] SEL_DEST2 = 2'd2;
    localparam logic [1:0] SEL_IDLE  = 2'd3;

endpackage

// File: rtl/load_route_ctrl.sv
// Upstream sequencer for the 1-to-3 routing demux.
// Accepts a valid/ready stream of words and routes the first LEN0 words to destination 0,
// the next LEN1 to destination 1 and the next LEN2 to destination 2. Each accepted word is
// presented one cycle later on data_out/sel with a write strobe and per-destination address.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, abort        begin a sequence (IDLE only) / return to IDLE from anywhere
//   in_data, in_valid   incoming stream; in_ready is high in the load states unless abort
//   data_out, sel       to demux; sel = 3 when no word is being written
//   wr_en, wr_addr      write strobe and word index within the current destination
//   busy, done          high in load states / one-cycle pulse in DONE
module load_route_ctrl
    import route_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN0   = 784,
    parameter int unsigned LEN1   = 7840,
    parameter int unsigned LEN2   = 10,
    parameter int unsigned ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        sel,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST0 = ADDR_W'(LEN0 - 1);
    localparam logic [ADDR_W-1:0] LAST1 = ADDR_W'(LEN1 - 1);
    localparam logic [ADDR_W-1:0] LAST2 = ADDR_W'(LEN2 - 1);

    load_state_t       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [1:0]        sel_q, sel_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

    logic              loading;
    logic              accept;
    logic [ADDR_W-1:0] last_idx;
    logic [1:0]        cur_sel;
    load_state_t       next_phase;

    // Per-phase final index, destination code and successor state.
    always_comb begin
        last_idx   = LAST0;
        cur_sel    = SEL_IDLE;
        next_phase = IDLE;
        unique case (state_q)
            LOAD0: begin
                last_idx   = LAST0;
                cur_sel    = SEL_DEST0;
                next_phase = LOAD1;
            end
            LOAD1: begin
                last_idx   = LAST1;
                cur_sel    = SEL_DEST1;
                next_phase = LOAD2;
            end
            LOAD2: begin
                last_idx   = LAST2;
                cur_sel    = SEL_DEST2;
                next_phase = DONE;
            end
            default: ;
        endcase
    end

    assign loading  = (state_q == LOAD0) || (state_q == LOAD1) || (state_q == LOAD2);
    // Ready depends only on state and abort so upstream never sees a valid->ready loop.
    assign in_ready = loading && !abort;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD0;
                    cnt_d   = '0;
                end
            end
            LOAD0, LOAD1, LOAD2: begin
                if (accept) begin
                    if (cnt_q == last_idx) begin
                        cnt_d   = '0;
                        state_d = next_phase;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort overrides everything, including a same-cycle start in IDLE.
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_comb begin
        data_out_d = '0;
        sel_d      = SEL_IDLE;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        if (accept) begin
            data_out_d = in_data;
            sel_d      = cur_sel;
            wr_en_d    = 1'b1;
            wr_addr_d  = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            sel_q      <= SEL_IDLE;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            sel_q      <= sel_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

    assign data_out = data_out_q;
    assign sel      = sel_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign busy     = loading;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_load_route_ctrl.sv
module tb_load_route_ctrl;

    localparam int L0    = 4;
    localparam int L1    = 3;
    localparam int L2    = 2;
    localparam int TOTAL = L0 + L1 + L2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_out;
    logic [1:0]  sel;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic        busy, done;

    int total = 0;
    int bad   = 0;

    // Reference model: sequence position, not FSM state.
    bit          m_active;
    bit          m_done;
    int          m_nacc;
    logic [15:0] e_data;
    logic [1:0]  e_sel;
    logic        e_wr;
    logic [2:0]  e_addr;

    load_route_ctrl #(
        .DATA_W(16), .LEN0(L0), .LEN1(L1), .LEN2(L2), .ADDR_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .sel(sel), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_done   = 0;
        m_nacc   = 0;
        e_data   = '0;
        e_sel    = 2'd3;
        e_wr     = 1'b0;
        e_addr   = '0;
    endtask

    task automatic chk_outputs(input string ph);
        chk({ph, ".data_out"}, 32'(data_out), 32'(e_data));
        chk({ph, ".sel"},      32'(sel),      32'(e_sel));
        chk({ph, ".wr_en"},    32'(wr_en),    32'(e_wr));
        chk({ph, ".wr_addr"},  32'(wr_addr),  32'(e_addr));
        chk({ph, ".busy"},     32'(busy),     32'(m_active));
        chk({ph, ".done"},     32'(done),     32'(m_done));
    endtask

    // One clock: drive inputs, check ready, advance model and DUT, check registered outputs.
    task automatic step(input string ph, input logic v, input logic [15:0] d,
                        input logic s, input logic a);
        bit acc, pre_done;
        int dest, base;
        in_valid = v; in_data = d; start = s; abort = a;
        #1;
        chk({ph, ".in_ready"}, 32'(in_ready), 32'(m_active && !a));
        pre_done = m_done;
        acc = m_active && v && !a;
        if (acc) begin
            dest   = (m_nacc < L0) ? 0 : (m_nacc < L0 + L1) ? 1 : 2;
            base   = (dest == 0) ? 0 : (dest == 1) ? L0 : L0 + L1;
            e_wr   = 1'b1;
            e_sel  = 2'(dest);
            e_addr = 3'(m_nacc - base);
            e_data = d;
            m_nacc++;
        end else begin
            e_wr   = 1'b0;
            e_sel  = 2'd3;
            e_data = '0;
        end
        m_done = 0;
        if (a) begin
            m_active = 0;
            m_nacc   = 0;
        end else if (acc && m_nacc == TOTAL) begin
            m_active = 0;
            m_done   = 1;
            m_nacc   = 0;
        end else if (!m_active && !pre_done && s) begin
            m_active = 1;
            m_nacc   = 0;
        end
        @(posedge clk);
        #1;
        chk_outputs(ph);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_outputs("reset");
        chk("reset.in_ready", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        step("idle", 0, 16'h0, 0, 0);

        // Full stream, valid every cycle.
        step("t2.start", 0, 16'h0, 1, 0);
        for (int i = 0; i < TOTAL; i++) step("t2.word", 1, 16'(i + 1), 0, 0);
        step("t2.tail", 0, 16'h0, 0, 0);
        step("t2.tail", 0, 16'h0, 0, 0);

        // Valid toggling with random data.
        step("t3.start", 0, 16'h0, 1, 0);
        guard = 0;
        while (m_active && guard < 40) begin
            step("t3.word", logic'(guard % 2 == 0), 16'($urandom), 0, 0);
            guard++;
        end
        chk("t3.completed", 32'(m_active), 32'(0));
        step("t3.tail", 0, 16'h0, 0, 0);

        // Abort after five accepts with a word offered.
        step("t4.start", 0, 16'h0, 1, 0);
        for (int i = 0; i < 5; i++) step("t4.word", 1, 16'($urandom), 0, 0);
        step("t4.abort", 1, 16'hdead, 0, 1);
        step("t4.idle", 1, 16'hbeef, 0, 0);
        step("t4.restart", 0, 16'h0, 1, 0);
        for (int i = 0; i < 2; i++) step("t4.word", 1, 16'($urandom), 0, 0);
        step("t4.abort2", 0, 16'h0, 0, 1);

        // Start during LOAD1 ignored; start+abort in IDLE stays idle.
        step("t5.start", 0, 16'h0, 1, 0);
        for (int i = 0; i < 5; i++) step("t5.word", 1, 16'($urandom), 0, 0);
        step("t5.start_busy", 1, 16'($urandom), 1, 0);
        guard = 0;
        while (m_active && guard < 40) begin
            step("t5.word", logic'($urandom_range(0, 1)), 16'($urandom), logic'($urandom_range(0, 1)), 0);
            guard++;
        end
        chk("t5.completed", 32'(m_active), 32'(0));
        step("t5.start_done", 0, 16'h0, 1, 0);
        step("t5.start_abort", 1, 16'h1234, 1, 1);
        step("t5.idle", 1, 16'h5678, 0, 0);

        // Async reset while in LOAD2.
        step("t6.start", 0, 16'h0, 1, 0);
        for (int i = 0; i < L0 + L1 + 1; i++) step("t6.word", 1, 16'($urandom), 0, 0);
        chk("t6.in_load2", 32'(busy), 32'(1));
        #1;
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        model_reset();
        chk_outputs("t6.async");
        chk("t6.async.in_ready", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("t6.after", 1, 16'h4321, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
